// File: rtl/playlist_mcu.sv
// Playlist control unit: sequences playback over NUM_SONGS songs with
// previous/next navigation, repeat modes, an end-of-playlist state, a
// multi-cycle player-reset pulse and optional auto-resume after a change.
module playlist_mcu #(
  parameter int NUM_SONGS    = 4,
  parameter int SONG_W       = 2,
  parameter int RESET_CYCLES = 2,
  parameter bit AUTO_PLAY    = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              play_button,
  input  logic              next_button,
  input  logic              prev_button,
  input  logic [1:0]        repeat_mode,
  input  logic              song_done,
  output logic              play,
  output logic              reset_player,
  output logic [SONG_W-1:0] song,
  output logic [1:0]        state
);

  // The counter only needs to reach RESET_CYCLES-1; keep it at least one bit wide.
  localparam int CNT_W = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES);

  localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_PAUSE  = 2'b00,
    ST_PLAY   = 2'b01,
    ST_CHANGE = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [SONG_W-1:0] song_q, song_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              resume_q, resume_d;

  logic [SONG_W-1:0] next_song, prev_song;
  logic              rep_all, rep_one;

  // Wrap-around neighbours use explicit compares so non-power-of-two playlists stay in range.
  always_comb begin
    next_song = (song_q == LAST_SONG) ? '0 : song_q + SONG_W'(1);
    prev_song = (song_q == '0) ? LAST_SONG : song_q - SONG_W'(1);
    rep_all   = (repeat_mode == 2'b01);
    rep_one   = (repeat_mode == 2'b10);
  end

  // State, song, change counter and resume flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_PAUSE;
      song_q   <= '0;
      cnt_q    <= '0;
      resume_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      song_q   <= song_d;
      cnt_q    <= cnt_d;
      resume_q <= resume_d;
    end
  end

  // Next-state logic; the song index is loaded on the same edge that enters CHANGE.
  always_comb begin
    state_d  = state_q;
    song_d   = song_q;
    cnt_d    = '0;
    resume_d = resume_q;
    case (state_q)
      ST_PAUSE: begin
        if (play_button) begin
          state_d = ST_PLAY;
        end else if (next_button) begin
          state_d  = ST_CHANGE;
          song_d   = next_song;
          resume_d = 1'b0;
        end else if (prev_button) begin
          state_d  = ST_CHANGE;
          song_d   = prev_song;
          resume_d = 1'b0;
        end
      end
      ST_PLAY: begin
        if (play_button) begin
          state_d = ST_PAUSE;
        end else if (next_button) begin
          state_d  = ST_CHANGE;
          song_d   = next_song;
          resume_d = AUTO_PLAY;
        end else if (prev_button) begin
          state_d  = ST_CHANGE;
          song_d   = prev_song;
          resume_d = AUTO_PLAY;
        end else if (song_done) begin
          if (rep_one) begin
            state_d  = ST_CHANGE;
            resume_d = AUTO_PLAY;
          end else if (rep_all || (song_q != LAST_SONG)) begin
            state_d  = ST_CHANGE;
            song_d   = next_song;
            resume_d = AUTO_PLAY;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_CHANGE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = resume_q ? ST_PLAY : ST_PAUSE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (play_button) begin
          state_d  = ST_CHANGE;
          song_d   = '0;
          resume_d = 1'b1;
        end else if (next_button) begin
          state_d  = ST_CHANGE;
          song_d   = '0;
          resume_d = 1'b0;
        end else if (prev_button) begin
          state_d  = ST_CHANGE;
          song_d   = LAST_SONG;
          resume_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_PAUSE;
      end
    endcase
  end

  // Outputs decode straight from registers, so an async reset drops reset_player at once.
  always_comb begin
    play         = (state_q == ST_PLAY);
    reset_player = (state_q == ST_CHANGE);
    song         = song_q;
    state        = state_q;
  end

endmodule

// File: tb/tb_playlist_mcu.sv
// Directed testbench for playlist_mcu with default parameters
// (4 songs, 2-cycle player reset, auto-play enabled).
module tb_playlist_mcu;

  logic       clk;
  logic       reset_n;
  logic       play_button;
  logic       next_button;
  logic       prev_button;
  logic [1:0] repeat_mode;
  logic       song_done;
  logic       play;
  logic       reset_player;
  logic [1:0] song;
  logic [1:0] state;

  int vectors;
  int miscompares;

  localparam logic [1:0] S_PAUSE  = 2'b00;
  localparam logic [1:0] S_PLAY   = 2'b01;
  localparam logic [1:0] S_CHANGE = 2'b10;
  localparam logic [1:0] S_DONE   = 2'b11;

  playlist_mcu #(
    .NUM_SONGS(4),
    .SONG_W(2),
    .RESET_CYCLES(2),
    .AUTO_PLAY(1'b1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .play_button(play_button),
    .next_button(next_button),
    .prev_button(prev_button),
    .repeat_mode(repeat_mode),
    .song_done(song_done),
    .play(play),
    .reset_player(reset_player),
    .song(song),
    .state(state)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs from the falling edge, then sample 1 unit after the rising edge.
  task automatic apply_stimulus(input logic pb, input logic nb, input logic vb,
                                input logic sd, input logic [1:0] rm);
    @(negedge clk);
    play_button = pb;
    next_button = nb;
    prev_button = vb;
    song_done   = sd;
    repeat_mode = rm;
    @(posedge clk);
    #1;
    play_button = 1'b0;
    next_button = 1'b0;
    prev_button = 1'b0;
    song_done   = 1'b0;
  endtask

  // Let n clock edges pass with no buttons pressed.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Compare all outputs against expected values.
  task automatic check_output(input string tag, input logic [1:0] exp_state,
                              input logic [1:0] exp_song, input logic exp_play,
                              input logic exp_rp);
    vectors++;
    assert ({state, song, play, reset_player} === {exp_state, exp_song, exp_play, exp_rp})
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed state=%b song=%0d play=%b reset_player=%b, expected state=%b song=%0d play=%b reset_player=%b",
             tag, state, song, play, reset_player, exp_state, exp_song, exp_play, exp_rp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    play_button = 1'b0;
    next_button = 1'b0;
    prev_button = 1'b0;
    song_done   = 1'b0;
    repeat_mode = 2'b00;

    #22;
    check_output("reset", S_PAUSE, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Play/pause toggle.
    apply_stimulus(1, 0, 0, 0, 2'b00);
    check_output("play1", S_PLAY, 2'd0, 1'b1, 1'b0);
    apply_stimulus(1, 0, 0, 0, 2'b00);
    check_output("pause1", S_PAUSE, 2'd0, 1'b0, 1'b0);

    // Previous from PAUSE at song 0 wraps to 3 and returns to PAUSE.
    apply_stimulus(0, 0, 1, 0, 2'b00);
    check_output("prev_pause_chg0", S_CHANGE, 2'd3, 1'b0, 1'b1);
    idle(1);
    check_output("prev_pause_chg1", S_CHANGE, 2'd3, 1'b0, 1'b1);
    idle(1);
    check_output("prev_pause_end", S_PAUSE, 2'd3, 1'b0, 1'b0);

    // Next from PLAY at song 3 wraps to 0 and resumes PLAY.
    apply_stimulus(1, 0, 0, 0, 2'b00);
    check_output("play_s3", S_PLAY, 2'd3, 1'b1, 1'b0);
    apply_stimulus(0, 1, 0, 0, 2'b00);
    check_output("next_wrap_chg0", S_CHANGE, 2'd0, 1'b0, 1'b1);
    idle(1);
    check_output("next_wrap_chg1", S_CHANGE, 2'd0, 1'b0, 1'b1);
    idle(1);
    check_output("next_wrap_end", S_PLAY, 2'd0, 1'b1, 1'b0);

    // Prev from PLAY back to song 3, still playing.
    apply_stimulus(0, 0, 1, 0, 2'b00);
    check_output("prev_play_chg", S_CHANGE, 2'd3, 1'b0, 1'b1);
    idle(2);
    check_output("prev_play_end", S_PLAY, 2'd3, 1'b1, 1'b0);

    // Repeat off at the last song ends the playlist; song_done then ignored.
    apply_stimulus(0, 0, 0, 1, 2'b00);
    check_output("done_enter", S_DONE, 2'd3, 1'b0, 1'b0);
    apply_stimulus(0, 0, 0, 1, 2'b00);
    check_output("done_ignore_sd", S_DONE, 2'd3, 1'b0, 1'b0);
    apply_stimulus(1, 0, 0, 0, 2'b00);
    check_output("done_play_chg", S_CHANGE, 2'd0, 1'b0, 1'b1);
    idle(2);
    check_output("done_play_end", S_PLAY, 2'd0, 1'b1, 1'b0);

    // Repeat off mid-playlist advances.
    apply_stimulus(0, 0, 0, 1, 2'b00);
    check_output("rep_off_mid_chg", S_CHANGE, 2'd1, 1'b0, 1'b1);
    idle(2);
    check_output("rep_off_mid_end", S_PLAY, 2'd1, 1'b1, 1'b0);

    // Repeat one keeps the song.
    apply_stimulus(0, 0, 0, 1, 2'b10);
    check_output("rep_one_chg", S_CHANGE, 2'd1, 1'b0, 1'b1);
    idle(2);
    check_output("rep_one_end", S_PLAY, 2'd1, 1'b1, 1'b0);

    // Walk to song 3, then repeat all wraps to 0.
    apply_stimulus(0, 1, 0, 0, 2'b01);
    idle(2);
    apply_stimulus(0, 1, 0, 0, 2'b01);
    idle(2);
    check_output("walk_to_s3", S_PLAY, 2'd3, 1'b1, 1'b0);
    apply_stimulus(0, 0, 0, 1, 2'b01);
    check_output("rep_all_chg", S_CHANGE, 2'd0, 1'b0, 1'b1);
    idle(2);
    check_output("rep_all_end", S_PLAY, 2'd0, 1'b1, 1'b0);

    // Repeat mode 11 behaves as off at the last song.
    apply_stimulus(0, 0, 1, 0, 2'b11);
    idle(2);
    apply_stimulus(0, 0, 0, 1, 2'b11);
    check_output("rep_11_done", S_DONE, 2'd3, 1'b0, 1'b0);

    // Next from DONE goes to song 0 and pauses.
    apply_stimulus(0, 1, 0, 0, 2'b00);
    check_output("done_next_chg", S_CHANGE, 2'd0, 1'b0, 1'b1);
    idle(2);
    check_output("done_next_end", S_PAUSE, 2'd0, 1'b0, 1'b0);

    // Back to DONE, then prev from DONE goes to the last song and pauses.
    apply_stimulus(1, 0, 0, 0, 2'b00);
    apply_stimulus(0, 0, 1, 0, 2'b00);
    idle(2);
    apply_stimulus(0, 0, 0, 1, 2'b00);
    check_output("done_again", S_DONE, 2'd3, 1'b0, 1'b0);
    apply_stimulus(0, 0, 1, 0, 2'b00);
    check_output("done_prev_chg", S_CHANGE, 2'd3, 1'b0, 1'b1);
    idle(2);
    check_output("done_prev_end", S_PAUSE, 2'd3, 1'b0, 1'b0);

    // Play beats next when both arrive together.
    apply_stimulus(1, 0, 0, 0, 2'b00);
    apply_stimulus(1, 1, 0, 0, 2'b00);
    check_output("play_over_next", S_PAUSE, 2'd3, 1'b0, 1'b0);

    // Buttons are ignored during CHANGE.
    apply_stimulus(1, 0, 0, 0, 2'b00);
    apply_stimulus(0, 1, 0, 0, 2'b00);
    check_output("ign_chg0", S_CHANGE, 2'd0, 1'b0, 1'b1);
    apply_stimulus(1, 1, 1, 1, 2'b00);
    check_output("ign_chg1", S_CHANGE, 2'd0, 1'b0, 1'b1);
    idle(1);
    check_output("ign_end", S_PLAY, 2'd0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of CHANGE.
    apply_stimulus(0, 1, 0, 0, 2'b00);
    check_output("pre_reset_chg", S_CHANGE, 2'd1, 1'b0, 1'b1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("async_reset", S_PAUSE, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(3);
    check_output("post_reset", S_PAUSE, 2'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/playlist_mcu.md
Name: playlist_mcu

Overview:
Parametrised successor to the music-player control unit. Sequences playback over a playlist of NUM_SONGS songs and adds:
- previous-song navigation
- repeat modes
- an explicit end-of-playlist state
- a multi-cycle player-reset pulse
- optional auto-resume after a song change
Sits between the button one-pulse/debounce logic and the song player/ROM; also drives the state-symbol display.

Parameters:
NUM_SONGS, 4, number of songs in the playlist; legal range 2..2^SONG_W.
SONG_W, 2, width of the song index.
RESET_CYCLES, 2, cycles reset_player stays high per song change; must be >= 1.
AUTO_PLAY, 1, 1: a change entered from PLAY returns to PLAY; 0: every change returns to PAUSE.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
play_button  input  1  play/pause toggle; one-cycle pulse from upstream.
next_button  input  1  skip to the next song; pulse.
prev_button  input  1  go to the previous song; pulse.
repeat_mode  input  2  00 off, 01 all, 10 one, 11 treated as 00; sampled when song_done is acted on.
song_done  input  1  player reports end of the current song.
play  output  1  high only in PLAY.
reset_player  output  1  high only in CHANGE.
song  output  SONG_W  current song index.
state  output  2  00 PAUSE, 01 PLAY, 10 CHANGE, 11 DONE.

Behaviour:
- Reset (reset_n low, asynchronous): state=PAUSE, song=0, play=0, reset_player=0, change counter=0, resume flag=0.
- All outputs are decoded directly from registers; no combinational path from inputs to outputs.
- Inputs are acted on every cycle the current state accepts them. A held button therefore re-triggers.
- Index arithmetic uses explicit compare, never natural overflow:
  - next(s) = (s==NUM_SONGS-1) ? 0 : s+1
  - prev(s) = (s==0) ? NUM_SONGS-1 : s-1
- Song register is loaded on the same edge that enters CHANGE. The player therefore sees the new index for the whole reset_player pulse.
- PAUSE (priority play > next > prev):
  - play_button -> PLAY.
  - next_button -> CHANGE, song=next, resume=0.
  - prev_button -> CHANGE, song=prev, resume=0.
  - song_done is ignored.
- PLAY (priority play > next > prev > song_done):
  - play_button -> PAUSE.
  - next_button -> CHANGE, song=next, resume=AUTO_PLAY.
  - prev_button -> CHANGE, song=prev, resume=AUTO_PLAY.
  - song_done with repeat one -> CHANGE, song unchanged, resume=AUTO_PLAY.
  - song_done with repeat all -> CHANGE, song=next (wraps), resume=AUTO_PLAY.
  - song_done with repeat off and song<NUM_SONGS-1 -> CHANGE, song=next, resume=AUTO_PLAY.
  - song_done with repeat off and song==NUM_SONGS-1 -> DONE, song unchanged.
- CHANGE:
  - Counter loads 0 on entry and increments each cycle.
  - After exactly RESET_CYCLES cycles in CHANGE, go to PLAY if resume=1, else PAUSE.
  - All buttons and song_done are ignored while in CHANGE.
- DONE:
  - play=0, reset_player=0.
  - play_button -> CHANGE, song=0, resume=1 (this ignores AUTO_PLAY).
  - next_button -> CHANGE, song=0, resume=0.
  - prev_button -> CHANGE, song=NUM_SONGS-1, resume=0.
  - song_done is ignored.
- Reset asserted mid-CHANGE: reset_player drops immediately (asynchronously); counter and resume flag clear.
- song is never >= NUM_SONGS in any state.

Test Plan:
1. Reset, then play pulse -> state 01, play=1, song=0. Second play pulse -> state 00, play=0.
2. Defaults, in PLAY with song=3, next pulse -> song=0 on the same edge that state becomes 10. reset_player high for exactly 2 cycles, then state 01.
3. PAUSE with song=0, prev pulse -> song=3, CHANGE for 2 cycles, then state 00 with play=0.
4. repeat_mode=00, PLAY with song=3, song_done -> state 11, song=3, play=0. Then play pulse -> song=0, CHANGE, then PLAY.
5. repeat_mode=10, PLAY with song=1, song_done -> CHANGE, song stays 1, returns to PLAY. Same with repeat_mode=01 at song=3 -> song=0.
6. Simultaneous play and next in PLAY -> PAUSE and song unchanged. next pulse during CHANGE -> ignored. reset_n low mid-CHANGE -> reset_player=0, song=0, state 00 immediately.
